// File: rtl/recovery_pc_restore.sv
// recovery_pc_restore
//
// Sequences a program-counter restore after an HMR recovery request:
// halts the core, reads the recovery PC storage once, hands the stored PC
// (and, if flagged, the stored branch target) to the core, then clears the
// storage and reports completion.
//
// Parameters
//   AddrWidth   : program-counter / branch-address width
//   HaltTimeout : cycles to wait in HALT for core_halted_i (1..255)
//
// Build option
//   RECOVERY_PC_ALIGN_CHECK_EN : when defined, a misaligned stored PC (bit0)
//   or misaligned stored branch target (bit0, branch flag set) skips the
//   restore handshake and finishes with error_o instead of done_o.
//   When undefined, error_o is tied 0.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i                       recovery request pulse (IDLE only)
//   core_halted_i                 core halt acknowledge (level)
//   core_pc_ready_i               core accepts core_pc_o
//   recovery_program_counter_i    stored PC
//   recovery_branch_i             stored branch flag
//   recovery_branch_addr_i        stored branch target
//   rpc_read_enable_o             storage read enable (READ)
//   rpc_clear_o                   storage clear (CLEAR)
//   rpc_write_block_o             blocks backup writes while not IDLE
//   core_halt_req_o               halt request, HALT..CLEAR
//   core_pc_valid_o, core_pc_o    restore address handshake
//   busy_o                        high in every state except IDLE
//   done_o, timeout_o, error_o    one-cycle status pulses
//   state_o                       current FSM state (debug)
//
// Handshake: core_pc_valid_o/core_pc_o are held stable while
// core_pc_ready_i is low; a transfer happens on a rising edge where both
// valid and ready are 1, and valid never drops before that edge.

module recovery_pc_restore #(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned HaltTimeout = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 core_halted_i,
  input  logic                 core_pc_ready_i,
  input  logic [AddrWidth-1:0] recovery_program_counter_i,
  input  logic                 recovery_branch_i,
  input  logic [AddrWidth-1:0] recovery_branch_addr_i,
  output logic                 rpc_read_enable_o,
  output logic                 rpc_clear_o,
  output logic                 rpc_write_block_o,
  output logic                 core_halt_req_o,
  output logic                 core_pc_valid_o,
  output logic [AddrWidth-1:0] core_pc_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic                 error_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HALT       = 3'd1,
    READ       = 3'd2,
    RESTORE_PC = 3'd3,
    RESTORE_BR = 3'd4,
    CLEAR      = 3'd5
  } state_e;

  // Counter value on the last HALT cycle allowed before giving up.
  localparam logic [7:0] TimeoutLast = 8'(HaltTimeout - 1);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
  logic [AddrWidth-1:0] pc_q;
  logic                 br_q;
  logic [AddrWidth-1:0] br_addr_q;

`ifdef RECOVERY_PC_ALIGN_CHECK_EN
  // Remembers that the current pass ends through CLEAR because of an
  // alignment fault, so CLEAR reports error_o rather than done_o.
  logic err_q, err_d;
  logic align_bad;

  // Evaluated on the values being captured in READ, so the decision matches
  // what the captured registers will hold.
  assign align_bad = recovery_program_counter_i[0] |
                     (recovery_branch_i & recovery_branch_addr_i[0]);
`endif

  // Next state and counters.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`ifdef RECOVERY_PC_ALIGN_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = HALT;
          cnt_d   = 8'd0;
`ifdef RECOVERY_PC_ALIGN_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      HALT: begin
        if (core_halted_i) begin
          state_d = READ;
        end else if (cnt_q == TimeoutLast) begin
          // Give up without touching storage; timeout_o shows in IDLE.
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      READ: begin
        state_d = RESTORE_PC;
`ifdef RECOVERY_PC_ALIGN_CHECK_EN
        if (align_bad) begin
          state_d = CLEAR;
          err_d   = 1'b1;
        end
`endif
      end
      RESTORE_PC: begin
        if (core_pc_ready_i) begin
          state_d = br_q ? RESTORE_BR : CLEAR;
        end
      end
      RESTORE_BR: begin
        if (core_pc_ready_i) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the state register only, so reset forces them
  // all to zero as soon as rst_ni falls.
  always_comb begin
    rpc_read_enable_o = 1'b0;
    rpc_clear_o       = 1'b0;
    rpc_write_block_o = 1'b0;
    core_halt_req_o   = 1'b0;
    core_pc_valid_o   = 1'b0;
    core_pc_o         = '0;
    busy_o            = 1'b0;
    done_o            = 1'b0;
    error_o           = 1'b0;
    if (state_q != IDLE) begin
      busy_o            = 1'b1;
      rpc_write_block_o = 1'b1;
      core_halt_req_o   = 1'b1;
    end
    case (state_q)
      READ: rpc_read_enable_o = 1'b1;
      RESTORE_PC: begin
        core_pc_valid_o = 1'b1;
        core_pc_o       = pc_q;
      end
      RESTORE_BR: begin
        core_pc_valid_o = 1'b1;
        core_pc_o       = br_addr_q;
      end
      CLEAR: begin
        rpc_clear_o = 1'b1;
`ifdef RECOVERY_PC_ALIGN_CHECK_EN
        done_o      = ~err_q;
        error_o     = err_q;
`else
        done_o      = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign timeout_o = timeout_q;
  assign state_o   = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= '0;
      br_q      <= 1'b0;
      br_addr_q <= '0;
    end else if (state_q == READ) begin
      pc_q      <= recovery_program_counter_i;
      br_q      <= recovery_branch_i;
      br_addr_q <= recovery_branch_addr_i;
    end
  end

`ifdef RECOVERY_PC_ALIGN_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: doc/recovery_pc_restore.md
RECOVERY_PC_RESTORE -- requirements
Module: recovery_pc_restore

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 32, meaning the program-counter and branch-address width.
REQ-002 The block SHALL have parameter HaltTimeout, default 16, meaning the maximum cycles to wait for core halt acknowledge (valid range 1..255).
REQ-003 The block SHALL have port clk_i, input, 1 bit, clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port start_i, input, 1 bit, recovery request pulse from the HMR unit.
REQ-006 The block SHALL have port core_halted_i, input, 1 bit, core halt acknowledge (level).
REQ-007 The block SHALL have port core_pc_ready_i, input, 1 bit, core accepts the presented restore address.
REQ-008 The block SHALL have port recovery_program_counter_i, input, AddrWidth bits, stored PC from the recovery PC storage.
REQ-009 The block SHALL have port recovery_branch_i, input, 1 bit, stored branch flag.
REQ-010 The block SHALL have port recovery_branch_addr_i, input, AddrWidth bits, stored branch target.
REQ-011 The block SHALL have port rpc_read_enable_o, output, 1 bit, read enable to the recovery PC storage.
REQ-012 The block SHALL have port rpc_clear_o, output, 1 bit, clear to the recovery PC storage.
REQ-013 The block SHALL have port rpc_write_block_o, output, 1 bit, gates backup writes into storage while recovery runs.
REQ-014 The block SHALL have port core_halt_req_o, output, 1 bit, halt request to the core.
REQ-015 The block SHALL have port core_pc_valid_o, output, 1 bit, restore address valid.
REQ-016 The block SHALL have port core_pc_o, output, AddrWidth bits, restore address.
REQ-017 The block SHALL have ports busy_o, done_o, timeout_o, error_o, all outputs, 1 bit each: status level, completion pulse, halt-timeout pulse, alignment-error pulse.

Function
REQ-018 The FSM SHALL have states IDLE, HALT, READ, RESTORE_PC, RESTORE_BR, CLEAR.
REQ-019 In IDLE, start_i=1 SHALL move to HALT next cycle and clear the timeout counter; start_i SHALL be ignored in every other state.
REQ-020 HALT SHALL assert core_halt_req_o; on core_halted_i=1 it SHALL go to READ; otherwise the counter SHALL increment, and when it reaches HaltTimeout without acknowledge the FSM SHALL pulse timeout_o for one cycle and return to IDLE without clearing storage.
REQ-021 READ SHALL last exactly one cycle, assert rpc_read_enable_o, and register recovery_program_counter_i, recovery_branch_i and recovery_branch_addr_i internally; next state RESTORE_PC.
REQ-022 RESTORE_PC SHALL drive core_pc_valid_o=1 with core_pc_o=captured PC, both held stable until core_pc_ready_i=1 (valid/ready handshake, no drop while waiting).
REQ-023 On handshake in RESTORE_PC, the FSM SHALL go to RESTORE_BR if the captured branch flag is 1, else to CLEAR.
REQ-024 RESTORE_BR SHALL present the captured branch address with the same handshake rules, then go to CLEAR.
REQ-025 CLEAR SHALL last one cycle, assert rpc_clear_o, pulse done_o and return to IDLE.
REQ-026 core_halt_req_o SHALL be 1 in HALT through CLEAR inclusive; busy_o and rpc_write_block_o SHALL be 1 in every state except IDLE.
REQ-027 core_pc_valid_o SHALL be 0 and core_pc_o SHALL be all-zero outside RESTORE_PC/RESTORE_BR.
REQ-028 Deassertion of core_halted_i after HALT SHALL NOT abort the sequence.

Reset
REQ-029 Asserting rst_ni low at any time, including mid-sequence, SHALL immediately force IDLE, zero captured registers and counter, and drive every output to 0.

Configuration
REQ-030 With macro RECOVERY_PC_ALIGN_CHECK_EN defined, READ's next state SHALL be CLEAR with a one-cycle error_o pulse (and no done_o) when captured PC bit0=1, or captured branch flag=1 and captured branch address bit0=1; no restore handshake occurs.
REQ-031 Without RECOVERY_PC_ALIGN_CHECK_EN, error_o SHALL be tied 0 and no alignment check SHALL exist.

Verification
REQ-032 start_i pulse, core_halted_i after 3 cycles, PC=0x1C000080, branch=0, ready immediate -> core_pc_o=0x1C000080 for one valid cycle, rpc_clear_o then done_o one cycle each, busy_o low after.
REQ-033 branch=1, branch_addr=0x1C000100, ready delayed 4 cycles each -> valid held 5 cycles with PC, then 5 cycles with 0x1C000100, then done_o.
REQ-034 core_halted_i never asserted, HaltTimeout=16 -> timeout_o pulse 16 cycles after entering HALT, rpc_clear_o never asserted, IDLE.
REQ-035 rst_ni low while in RESTORE_PC waiting for ready -> all outputs 0 same cycle, IDLE after release; second start_i during busy ignored.
REQ-036 With RECOVERY_PC_ALIGN_CHECK_EN, PC=0x1C000081 -> no core_pc_valid_o, error_o and rpc_clear_o pulse, no done_o.
